// File: rtl/bip_control.sv
// bip_control: accumulator CPU fetch/decode/execute/halt sequencer; define BIP_DEBUG_STEP_EN for single-step input i_Step.
module bip_control #(
  parameter int NBITS_PC  = 11,
  parameter int NBITS_I   = 16,
  parameter int NBITS_OPC = 5,
  parameter int NBITS_O   = 11
) (
  input  logic                i_clock,
  input  logic                i_reset,
`ifdef BIP_DEBUG_STEP_EN
  input  logic                i_Step,
`endif
  input  logic [NBITS_I-1:0]  i_Instruction,
  output logic [NBITS_PC-1:0] o_PC,
  output logic [1:0]          o_SelA,
  output logic                o_SelB,
  output logic                o_WrAcc,
  output logic                o_Op,
  output logic                o_WrRam,
  output logic                o_RdRam,
  output logic [NBITS_O-1:0]  o_Operand,
  output logic                o_Halt
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [NBITS_OPC-1:0] OP_HLT = 0, OP_STO = 1, OP_LD = 2, OP_LDI = 3;
  localparam logic [NBITS_OPC-1:0] OP_ADD = 4, OP_ADDI = 5, OP_SUB = 6, OP_SUBI = 7;
  state_t state_q, state_d;
  logic [NBITS_PC-1:0] pc_q, pc_d;
  logic [NBITS_I-1:0] ir_q, ir_d;
  logic [NBITS_OPC-1:0] opc;
  logic go, exec, hlt, sto, ld, ldi, add, addi, sub, subi;
`ifdef BIP_DEBUG_STEP_EN
  assign go = i_Step;
`else
  assign go = 1'b1;
`endif
  assign opc = ir_q[NBITS_I-1 -: NBITS_OPC];
  always_ff @(posedge i_clock or posedge i_reset)
    if (i_reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH:   state_d = go ? DECODE : FETCH;
      DECODE: begin
        ir_d    = i_Instruction;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = (opc == OP_HLT) ? HALT : FETCH;
        pc_d    = (opc == OP_HLT) ? pc_q : pc_q + 1'b1;
      end
      default: state_d = HALT;
    endcase
  end
  assign exec = state_q == EXEC;
  assign hlt  = exec && opc == OP_HLT;
  assign sto  = exec && opc == OP_STO;
  assign ld   = exec && opc == OP_LD;
  assign ldi  = exec && opc == OP_LDI;
  assign add  = exec && opc == OP_ADD;
  assign addi = exec && opc == OP_ADDI;
  assign sub  = exec && opc == OP_SUB;
  assign subi = exec && opc == OP_SUBI;
  always_comb begin
    o_PC      = pc_q;
    o_Operand = ir_q[NBITS_O-1:0];
    o_SelA    = (add | addi | sub | subi) ? 2'b10 : ldi ? 2'b01 : 2'b00;
    o_SelB    = addi | subi;
    o_Op      = sub | subi;
    o_WrAcc   = ld | ldi | add | addi | sub | subi;
    o_WrRam   = sto;
    o_RdRam   = ld | add | sub;
    o_Halt    = hlt || state_q == HALT;
  end
endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: table-driven, directed and randomized checks of bip_control against a program-level reference model.
module tb_bip_control;
  typedef struct packed {
    logic [1:0] sela;
    logic selb, wracc, op, wrram, rdram, halt;
  } ctl_t;
  typedef struct {
    logic [15:0] instr;
    ctl_t ctl;
  } vec_t;
  logic i_clock = 0, i_reset = 1;
  logic [15:0] i_Instruction = '0;
  logic [10:0] o_PC, o_Operand;
  logic [1:0] o_SelA;
  logic o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_Halt;
`ifdef BIP_DEBUG_STEP_EN
  logic i_Step = 1;
`endif
  logic [15:0] mem [0:2047];
  ctl_t act;
  ctl_t expc [0:63];
  vec_t tbl [7];
  int tests = 0, fails = 0;
  bip_control dut (
    .i_clock(i_clock), .i_reset(i_reset),
`ifdef BIP_DEBUG_STEP_EN
    .i_Step(i_Step),
`endif
    .i_Instruction(i_Instruction), .o_PC(o_PC), .o_SelA(o_SelA), .o_SelB(o_SelB),
    .o_WrAcc(o_WrAcc), .o_Op(o_Op), .o_WrRam(o_WrRam), .o_RdRam(o_RdRam),
    .o_Operand(o_Operand), .o_Halt(o_Halt)
  );
  always #5 i_clock = ~i_clock;
  always @(posedge i_clock) i_Instruction <= mem[o_PC];
  assign act = {o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam, o_Halt};
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask
  function automatic ctl_t model(input logic [4:0] opc);
    ctl_t c;
    c = '0;
    case (opc)
      5'd0: c.halt = 1;
      5'd1: c.wrram = 1;
      5'd2: begin c.rdram = 1; c.wracc = 1; end
      5'd3: begin c.sela = 2'b01; c.wracc = 1; end
      5'd4, 5'd5, 5'd6, 5'd7: begin
        c.sela  = 2'b10;
        c.wracc = 1;
        c.selb  = opc inside {5'd5, 5'd7};
        c.op    = opc inside {5'd6, 5'd7};
        c.rdram = opc inside {5'd4, 5'd6};
      end
      default: c = '0;
    endcase
    return c;
  endfunction
  task automatic do_reset();
    i_reset = 1;
    @(posedge i_clock);
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 0;
  endtask
  // Starts at a FETCH negedge; program at mem[0..n-1], expectations in expc.
  task automatic run(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk({tag, " fetch"}, {o_PC, act}, {k[10:0], 8'h00});
      @(posedge i_clock); @(negedge i_clock);
      chk({tag, " decode"}, {o_PC, act}, {k[10:0], 8'h00});
      @(posedge i_clock); @(negedge i_clock);
      chk({tag, " exec"}, {o_PC, o_Operand, act}, {k[10:0], mem[k][10:0], expc[k]});
      if (expc[k].halt) begin
        for (int c = 0; c < 20; c++) begin
          @(posedge i_clock); @(negedge i_clock);
          chk({tag, " halt"}, {o_Halt, o_PC, act[7:1]}, {1'b1, k[10:0], 7'h00});
        end
        return;
      end
      @(posedge i_clock); @(negedge i_clock);
    end
  endtask
  initial begin
    tbl[0] = '{16'h1805, 8'b01010000};
    tbl[1] = '{16'h2803, 8'b10110000};
    tbl[2] = '{16'hF82A, 8'b00000000};
    tbl[3] = '{16'h1004, 8'b00010010};
    tbl[4] = '{16'h3005, 8'b10011010};
    tbl[5] = '{16'h0810, 8'b00000100};
    tbl[6] = '{16'h0000, 8'b00000001};
    for (int a = 0; a < 2048; a++) mem[a] = 16'hF800;
    @(negedge i_clock);
    chk("reset", {o_PC, o_Operand, act}, 30'h0);
    for (int k = 0; k < 7; k++) begin
      mem[k]  = tbl[k].instr;
      expc[k] = tbl[k].ctl;
    end
    do_reset();
    run("table", 7);
    // Asynchronous reset in the middle of a STO execute cycle.
    mem[0] = 16'h1807;
    mem[1] = 16'h0810;
    do_reset();
    repeat (5) @(posedge i_clock);
    @(negedge i_clock);
    chk("sto exec", {o_WrRam, o_PC}, {1'b1, 11'd1});
    #2 i_reset = 1;
    #1 chk("async reset", {o_WrRam, o_PC, o_Halt, act}, 21'h0);
    @(posedge i_clock);
    @(negedge i_clock);
    i_reset = 0;
    chk("post reset pc", {21'h0, o_PC}, 32'h0);
    @(posedge i_clock); @(posedge i_clock); @(negedge i_clock);
    chk("post reset ldi", {o_PC, o_Operand, act}, {11'd0, 11'd7, 8'b01010000});
    // PC wraps after the NOP at the last address.
    for (int a = 0; a < 2048; a++) mem[a] = 16'hF800 | 16'(a & 11'h3FF);
    do_reset();
    repeat (3 * 2047 + 2) @(posedge i_clock);
    @(negedge i_clock);
    chk("wrap exec", {o_PC, act}, {11'h7FF, 8'h00});
    @(posedge i_clock); @(negedge i_clock);
    chk("wrap fetch", {21'h0, o_PC}, 32'h0);
    // Random programs against the reference model.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = 40;
      for (int k = 0; k < n - 1; k++) begin
        int sel;
        logic [4:0] opc;
        sel = int'($urandom_range(0, 9));
        opc = sel < 7 ? 5'(sel + 1) : 5'($urandom_range(8, 31));
        mem[k]  = {opc, 11'($urandom)};
        expc[k] = model(opc);
      end
      mem[n-1]  = {5'd0, 11'($urandom)};
      expc[n-1] = model(5'd0);
      do_reset();
      run("random", n);
    end
`ifdef BIP_DEBUG_STEP_EN
    mem[0] = 16'h1805;
    mem[1] = 16'h2803;
    i_Step = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(posedge i_clock); @(negedge i_clock);
      chk("step idle", {o_PC, act}, {11'd0, 8'h00});
    end
    i_Step = 1;
    @(posedge i_clock); @(negedge i_clock);
    i_Step = 0;
    @(posedge i_clock); @(negedge i_clock);
    chk("step exec", {o_PC, act}, {11'd0, 8'b01010000});
    for (int c = 0; c < 5; c++) begin
      @(posedge i_clock); @(negedge i_clock);
      chk("step wait", {o_PC, act}, {11'd1, 8'h00});
    end
    i_Step = 1;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the accumulator datapath. Fetches 16-bit instructions from program memory, decodes opcode/operand and drives the accumulator-select, B-operand-select, ALU-op and data-RAM strobes consumed by the datapath multiplexers.
- Owns the program counter and a fetch/decode/execute/halt state machine.
- Sits between program memory and the datapath multiplexer/ALU/data-RAM block.

Parameters:
- NBITS_PC, 11, program counter width (program memory depth 2^NBITS_PC).
- NBITS_I, 16, instruction width.
- NBITS_OPC, 5, opcode field width (instruction bits [NBITS_I-1 : NBITS_I-NBITS_OPC]).
- NBITS_O, 11, operand field width (instruction bits [NBITS_O-1:0]).

Ports:
- i_clock  in  1  system clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_Instruction  in  NBITS_I  program memory read data; registered memory, valid one cycle after o_PC.
- o_PC  out  NBITS_PC  program memory address.
- o_SelA  out  2  accumulator source: 00 data RAM, 01 immediate extension, 10 ALU result.
- o_SelB  out  1  ALU B operand: 0 data RAM, 1 immediate extension.
- o_WrAcc  out  1  accumulator write enable.
- o_Op  out  1  ALU operation: 0 add, 1 subtract.
- o_WrRam  out  1  data RAM write strobe (accumulator -> RAM[o_Operand]).
- o_RdRam  out  1  data RAM read strobe.
- o_Operand  out  NBITS_O  operand field of the current instruction (RAM address or immediate).
- o_Halt  out  1  processor halted.

Behaviour:
- Reset: state FETCH; o_PC=0; IR=0; all control outputs 0; o_Halt=0. Reset applies asynchronously in any state, including mid-instruction; no RAM write may complete after reset asserts.
- States: FETCH -> DECODE -> EXEC -> FETCH. HALT is terminal until reset. Each instruction takes 3 cycles.
- FETCH:
  - o_PC holds the address.
  - All strobes are 0.
  - Next state is DECODE.
- DECODE:
  - IR <= i_Instruction.
  - o_RdRam=1 for the cycle after the latch (EXEC) only when the opcode is LD, ADD or SUB.
- EXEC:
  - Control outputs are decoded from IR and held for exactly this cycle.
  - o_Operand = IR[NBITS_O-1:0]; it stays stable from DECODE+1 until the next DECODE.
- Opcodes and EXEC outputs (fields not listed are 0):
  - 00000 HLT: state HALT, o_Halt=1, PC not incremented.
  - 00001 STO: o_WrRam=1.
  - 00010 LD: o_RdRam=1, o_SelA=00, o_WrAcc=1.
  - 00011 LDI: o_SelA=01, o_WrAcc=1.
  - 00100 ADD: o_RdRam=1, o_SelB=0, o_Op=0, o_SelA=10, o_WrAcc=1.
  - 00101 ADDI: o_SelB=1, o_Op=0, o_SelA=10, o_WrAcc=1.
  - 00110 SUB: o_RdRam=1, o_SelB=0, o_Op=1, o_SelA=10, o_WrAcc=1.
  - 00111 SUBI: o_SelB=1, o_Op=1, o_SelA=10, o_WrAcc=1.
  - Any other opcode: NOP, all strobes 0, PC increments.
- PC: incremented on leaving EXEC (except HLT). Arithmetic is modulo 2^NBITS_PC, so 0x7FF wraps to 0x000 with no flag.
- HALT:
  - o_Halt=1; all strobes 0.
  - o_PC frozen at the HLT address.
  - Only i_reset exits.
- Outputs are registered or decoded from registered state only; no combinational path from i_Instruction to any output.

Optional Feature:
- Macro: BIP_DEBUG_STEP_EN.
- Defined:
  - Adds input port i_Step (1 bit, after i_reset).
  - The FSM stays in FETCH until i_Step=1 is sampled on a rising edge, then proceeds through one full instruction.
  - i_Step held high runs free.
  - i_Step is ignored in DECODE, EXEC and HALT.
- Undefined: i_Step does not exist and FETCH always advances after one cycle.

Test Plan:
- Reset: assert i_reset mid-EXEC of STO (o_WrRam=1) -> o_WrRam, o_PC, o_Halt drop to 0 immediately without waiting for a clock; after release the first fetch is at PC=0.
- Program LDI 5; ADDI 3; STO 0x010; HLT -> LDI EXEC: o_SelA=01, o_WrAcc=1, o_Operand=5. ADDI EXEC: o_SelB=1, o_Op=0, o_SelA=10. STO EXEC: o_WrRam=1, o_Operand=0x010. Then o_Halt=1 with o_PC=3 held for 20 cycles.
- LD 0x004; SUB 0x005 -> o_RdRam=1 during both EXEC cycles. LD: o_SelA=00. SUB: o_SelB=0, o_Op=1, o_SelA=10. All other strobes 0.
- Opcode 11111 at PC=2 -> no strobe asserted during its EXEC; next fetch at PC=3.
- PC wrap: NOP at address 0x7FF -> next o_PC=0x000.
- BIP_DEBUG_STEP_EN: i_Step=0 for 10 cycles -> o_PC constant and no strobes. A single-cycle i_Step pulse -> exactly one instruction executes, then the FSM waits again in FETCH.
